// File: rtl/light_level_sequencer.sv
// Level Up board game-play controller: generates and scrolls the three lane patterns,
// scores strikes against the hit zone (bit 0) and runs the level/speed state machine.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// PLAY  | lanes scrolling, strikes being scored each tick
// LVLUP | single cycle: bump level, clear lanes and window timer
// OVER  | miss limit reached; everything frozen until start
module light_level_sequencer #(
  parameter int unsigned TICK_BASE      = 25000000,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter int unsigned MAX_MISSES     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hit,
  input  logic [15:0] seed,
  output logic [16:0] l1,
  output logic [16:0] l2,
  output logic [16:0] l3,
  output logic [1:0]  select,
  output logic [1:0]  level,
  output logic [7:0]  score,
  output logic [2:0]  misses,
  output logic        playing,
  output logic        game_over
);

  localparam int CW = $clog2(TICK_BASE);
  localparam logic [CW-1:0] LAST_L1 = CW'(TICK_BASE - 1);
  localparam logic [CW-1:0] LAST_L2 = CW'((TICK_BASE >> 1) - 1);
  localparam logic [CW-1:0] LAST_L3 = CW'((TICK_BASE >> 2) - 1);
  localparam logic [7:0]  HPL       = 8'(HITS_PER_LEVEL);
  localparam logic [2:0]  MISS_MAX  = 3'(MAX_MISSES);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_LVLUP = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_last;
  logic [15:0]   lfsr, lfsr_nx;
  logic [7:0]    hits, hits_nx, score_nx;
  logic [2:0]    misses_nx;
  logic          strike, strike_now, tick, target, good, bad;

  always_comb begin
    unique case (level)
      2'd2:    cnt_last = LAST_L2;
      2'd3:    cnt_last = LAST_L3;
      default: cnt_last = LAST_L1;
    endcase
  end

  // A strike on the tick cycle itself still belongs to the window that is closing.
  assign tick       = (state == S_PLAY) && (cnt == cnt_last);
  assign strike_now = strike | hit;
  assign target     = l1[0] | (level[1] & l2[0]) | ((level == 2'd3) & l3[0]);
  assign good       = tick & target & strike_now;
  assign bad        = tick & (target ^ strike_now);
  assign lfsr_nx    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  assign score_nx  = (good && score != 8'hFF) ? score + 8'd1 : score;
  assign hits_nx   = (good && hits != HPL) ? hits + 8'd1 : hits;
  assign misses_nx = (bad && misses != MISS_MAX) ? misses + 3'd1 : misses;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_OVER: if (start) state_nx = S_PLAY;
      S_PLAY: begin
        if (tick) begin
          if (misses_nx == MISS_MAX)
            state_nx = S_OVER;
          else if (hits_nx == HPL && level != 2'd3)
            state_nx = S_LVLUP;
        end
      end
      S_LVLUP: state_nx = S_PLAY;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lfsr      <= LFSR_INIT;
      hits      <= '0;
      strike    <= 1'b0;
      l1        <= '0;
      l2        <= '0;
      l3        <= '0;
      select    <= '0;
      level     <= '0;
      score     <= '0;
      misses    <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      playing   <= (state_nx == S_PLAY) || (state_nx == S_LVLUP);
      game_over <= (state_nx == S_OVER);
      unique case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            lfsr   <= (seed == 16'h0000) ? LFSR_INIT : seed;
            level  <= 2'd1;
            select <= 2'b00;
            score  <= '0;
            misses <= '0;
            hits   <= '0;
            strike <= 1'b0;
            cnt    <= '0;
            l1     <= '0;
            l2     <= '0;
            l3     <= '0;
          end
        end
        S_PLAY: begin
          score  <= score_nx;
          misses <= misses_nx;
          hits   <= hits_nx;
          if (tick) begin
            cnt    <= '0;
            strike <= 1'b0;
            l1     <= {lfsr[0], l1[16:1]};
            l2     <= level[1] ? {lfsr[5], l2[16:1]} : 17'd0;
            l3     <= (level == 2'd3) ? {lfsr[10], l3[16:1]} : 17'd0;
            lfsr   <= lfsr_nx;
          end else begin
            cnt <= cnt + CW'(1);
            if (hit) strike <= 1'b1;
          end
        end
        S_LVLUP: begin
          level  <= level + 2'd1;
          select <= {level == 2'd2, 1'b1};
          hits   <= '0;
          strike <= 1'b0;
          cnt    <= '0;
          l1     <= '0;
          l2     <= '0;
          l3     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_light_level_sequencer.sv
// Directed bench for light_level_sequencer: a lane/score model pushes expected outputs
// into a scoreboard as each step is driven; outputs are popped and compared after the edge.
module tb_light_level_sequencer;
  localparam int TB_TICK = 4;
  localparam int TB_HPL  = 2;
  localparam int TB_MM   = 3;

  logic        clk = 1'b0;
  logic        reset, start, hit;
  logic [15:0] seed;
  logic [16:0] l1, l2, l3;
  logic [1:0]  select, level;
  logic [7:0]  score;
  logic [2:0]  misses;
  logic        playing, game_over;

  always #5 clk = ~clk;

  light_level_sequencer #(
    .TICK_BASE(TB_TICK), .HITS_PER_LEVEL(TB_HPL), .MAX_MISSES(TB_MM)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hit(hit), .seed(seed),
    .l1(l1), .l2(l2), .l3(l3), .select(select), .level(level),
    .score(score), .misses(misses), .playing(playing), .game_over(game_over)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // model: mst 0=idle 1=play 2=lvlup 3=over
  logic [16:0] m1, m2, m3;
  logic [15:0] mlfsr;
  int mlvl, mscore, mmiss, mhits, mst;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic int period();
    if (mlvl == 2) return TB_TICK / 2;
    if (mlvl == 3) return TB_TICK / 4;
    return TB_TICK;
  endfunction

  function automatic bit target();
    return m1[0] | ((mlvl >= 2) && m2[0]) | ((mlvl == 3) && m3[0]);
  endfunction

  function automatic int exp_sel();
    if (mst == 0 || mlvl == 1) return 0;
    if (mlvl == 2) return 1;
    return 3;
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic guard(input bit ok, input string tag);
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL %s loop bound expired observed=0 expected=1", tag);
    end
  endtask

  task automatic push_snapshot();
    push("l1", 32'(m1));
    push("l2", 32'(m2));
    push("l3", 32'(m3));
    push("select", 32'(exp_sel()));
    push("level", 32'((mst == 0) ? 0 : mlvl));
    push("score", 32'(mscore));
    push("misses", 32'(mmiss));
    push("playing", 32'((mst == 1 || mst == 2) ? 1 : 0));
    push("game_over", 32'((mst == 3) ? 1 : 0));
  endtask

  task automatic compare_snapshot();
    check(32'(l1));
    check(32'(l2));
    check(32'(l3));
    check(32'(select));
    check(32'(level));
    check(32'(score));
    check(32'(misses));
    check(32'(playing));
    check(32'(game_over));
  endtask

  task automatic do_reset();
    m1 = '0; m2 = '0; m3 = '0; mlfsr = 16'hACE1;
    mlvl = 0; mscore = 0; mmiss = 0; mhits = 0; mst = 0;
    push_snapshot();
    reset = 1'b1; start = 1'b0; hit = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    compare_snapshot();
  endtask

  task automatic start_game(input logic [15:0] sd);
    mlfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
    m1 = '0; m2 = '0; m3 = '0;
    mlvl = 1; mscore = 0; mmiss = 0; mhits = 0; mst = 1;
    push_snapshot();
    start = 1'b1; seed = sd;
    @(posedge clk); #1;
    start = 1'b0;
    compare_snapshot();
  endtask

  // One full scroll window (period of the current level) ending on its tick edge.
  task automatic window(input logic [3:0] hm, input bit st);
    int p;
    bit strk, tgt;
    logic [16:0] pre1;
    p = period();
    strk = 1'b0;
    for (int c = 0; c < p; c++) if (hm[c]) strk = 1'b1;
    tgt  = target();
    pre1 = m1;
    if (tgt && strk) begin
      if (mscore < 255) mscore++;
      mhits++;
    end else if (tgt != strk) begin
      if (mmiss < TB_MM) mmiss++;
    end
    m3 = (mlvl == 3) ? {mlfsr[10], m3[16:1]} : 17'd0;
    m2 = (mlvl >= 2) ? {mlfsr[5], m2[16:1]} : 17'd0;
    m1 = {mlfsr[0], m1[16:1]};
    mlfsr = lfsr_step(mlfsr);
    if (mmiss == TB_MM) mst = 3;
    else if (mhits >= TB_HPL && mlvl < 3) mst = 2;
    if (p > 1) push("pre_tick_l1", 32'(pre1));
    push_snapshot();
    for (int c = 0; c < p; c++) begin
      hit = hm[c];
      start = st && (c == 0);
      @(posedge clk); #1;
      hit = 1'b0;
      start = 1'b0;
      if (p > 1 && c == p - 2) check(32'(l1));
    end
    compare_snapshot();
  endtask

  task automatic lvlup();
    push("lvlup_playing", 32'd1);
    push("lvlup_game_over", 32'd0);
    check(32'(playing));
    check(32'(game_over));
    mlvl++; mhits = 0; m1 = '0; m2 = '0; m3 = '0; mst = 1;
    push_snapshot();
    @(posedge clk); #1;
    compare_snapshot();
  endtask

  task automatic perfect_window(input bit auto_lvl);
    window(target() ? 4'b0001 : 4'b0000, 1'b0);
    if (auto_lvl && mst == 2) lvlup();
  endtask

  task automatic frozen_cycles(input int n);
    push_snapshot();
    for (int c = 0; c < n; c++) begin
      hit = 1'b1;
      @(posedge clk); #1;
      hit = 1'b0;
    end
    compare_snapshot();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0;
    reset = 1'b1; start = 1'b0; hit = 1'b0; seed = '0;
    @(posedge clk); #1;
    do_reset();

    // first game: seed 1, first tick exactly four cycles after start
    start_game(16'h0001);
    window(4'b0000, 1'b0);

    // triple strike in one target window counts once
    n = 0;
    while (!target() && n < 200) begin window(4'b0000, 1'b0); n++; end
    guard(n < 200, "wait_target_a");
    window(4'b0111, 1'b0);

    // strike on the tick cycle itself scores and completes level 1
    n = 0;
    while (!target() && n < 200) begin window(4'b0000, 1'b0); n++; end
    guard(n < 200, "wait_target_b");
    window(4'b1000, 1'b0);
    lvlup();

    n = 0;
    while (mlvl == 2 && n < 200) begin perfect_window(1'b1); n++; end
    guard(n < 200, "finish_level2");

    s0 = mscore;
    n = 0;
    while (mscore < s0 + 2 && n < 200) begin perfect_window(1'b1); n++; end
    guard(n < 200, "level3_hits");

    // start ignored in PLAY, then strike every window until the miss limit
    window(target() ? 4'b0001 : 4'b0000, 1'b1);
    n = 0;
    while (mst != 3 && n < 200) begin window(4'b0001, 1'b0); n++; end
    guard(n < 200, "reach_over");
    frozen_cycles(6);

    // restart from OVER with seed 0 (ACE1), play until a level-up is pending
    start_game(16'h0000);
    n = 0;
    while (mst != 2 && n < 300) begin perfect_window(1'b0); n++; end
    guard(n < 300, "reach_lvlup");
    do_reset();

    // reset mid-window with the strike flag set
    start_game(16'h0001);
    push("mid_window_playing", 32'd1);
    hit = 1'b1;
    @(posedge clk); #1;
    hit = 1'b0;
    check(32'(playing));
    do_reset();

    start_game(16'h0001);
    window(4'b0000, 1'b0);
    window(4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/light_level_sequencer.md
Name: light_level_sequencer

Overview:
Game-play controller that generates, scrolls and scores the three lane light patterns for the Level Up board. It owns the three 17-bit lane registers and drives the lane-combining adder: lanes go to its L1/L2/L3 inputs and `select` goes to its select input. It also runs the level state machine that enables more lanes and speeds up scrolling. It also scores player hits against the hit zone (bit 0 of the lanes).

Parameters:
TICK_BASE, 25000000, clock cycles per scroll step at level 1; level 2 uses TICK_BASE>>1, level 3 uses TICK_BASE>>2; must be >= 4.
HITS_PER_LEVEL, 8, correct hits required to advance one level; range 1..255.
MAX_MISSES, 4, miss count that ends the game; range 1..7.

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle start/restart pulse
hit  in  1  single-cycle player strike pulse, already debounced
seed  in  16  pattern LFSR seed, sampled on an accepted start
l1, l2, l3  out  17 each  lane registers for the adder; bit 0 is the hit zone
select  out  2  lane select for the adder: level 1 = 00, level 2 = 01, level 3 = 11; 10 is never driven
level  out  2  current level, 1..3; 0 when idle
score  out  8  total correct hits; saturates at 255
misses  out  3  miss count
playing  out  1  high in PLAY
game_over  out  1  high in OVER

Behaviour:
- All outputs are registered. On reset, every output is 0, the state is IDLE, and all internal counters and flags are 0. The LFSR resets to 16'hACE1.
- FSM states: IDLE, PLAY, LVLUP, OVER.
  - IDLE: on start, load LFSR (seed, or 16'hACE1 if seed == 0). Set level=1, score=0, misses=0; clear lanes and tick counter. Go to PLAY.
  - PLAY -> LVLUP when hits-in-level reaches HITS_PER_LEVEL and level < 3.
  - PLAY -> OVER when misses reaches MAX_MISSES. OVER takes priority if both occur on the same tick.
  - LVLUP lasts exactly one cycle: level += 1, hits-in-level = 0, lanes = 0, tick counter = 0. Then return to PLAY.
  - OVER: lanes hold their values; score and misses are frozen. On start, perform the same initialisation as from IDLE and go directly to PLAY.
  - start in PLAY or LVLUP is ignored.
- Tick counter (PLAY only): counts 0..P-1, where P is the period for the current level. The tick fires on the cycle count == P-1, and the count wraps to 0 on that cycle.
- Strike latch: hit in PLAY sets a strike flag. Multiple hits within one window count once. The flag clears on every tick.
- Scoring on each tick, evaluated with pre-shift lane values:
  - target = l1[0] | (level>=2 & l2[0]) | (level==3 & l3[0]).
  - A hit on the tick cycle itself belongs to the closing window.
  - target=1 with a strike: score+1 (saturating) and hits-in-level+1.
  - target=1 with no strike: misses+1.
  - target=0 with a strike: misses+1 (wrong press).
  - target=0 with no strike: no change.
- Scroll on the same tick. The new lane values are visible the cycle after the tick.
  - Each enabled lane shifts right by 1, with a new MSB: l1 gets lfsr[0], l2 gets lfsr[5], l3 gets lfsr[10].
  - Disabled lanes (l2 at level 1; l3 at levels 1–2) hold 0.
  - The LFSR then advances one step: 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback into bit 0.
- Level 3 has no further level-up; hits keep scoring.
- misses saturates at MAX_MISSES.
- playing = (state == PLAY || state == LVLUP); game_over = (state == OVER).
- Reset asserted in any state, including mid-window or in LVLUP, returns to the reset values on the next edge.

Test Plan:
Test parameters for all scenarios: TICK_BASE=4, HITS_PER_LEVEL=2, MAX_MISSES=3.
1. Reset, then start with seed=16'h0001 -> next cycle playing=1, level=1, select=00, l1=l2=l3=0. The first tick fires 4 cycles later. One cycle after that tick, l1[16]=1, l2=l3=0.
2. Run until l1[0]=1 and pulse hit 3 times in that window -> score increments by exactly 1, misses unchanged. A hit issued on the tick cycle itself also scores.
3. With 2 correct hits at level 1 -> a one-cycle LVLUP, then level=2, select=01, lanes=0, tick period 2 cycles. Repeat -> level=3, select=11, period 1. Further hits at level 3 keep level=3.
4. Strike while target=0 on 3 windows -> misses=3, game_over=1, playing=0, lanes frozen. start is ignored in PLAY but accepted in OVER: score=0, misses=0, level=1.
5. seed=0 on start -> LFSR loads 16'hACE1; the lane sequence matches a reference model seeded with ACE1.
6. Assert reset during LVLUP and mid-window with the strike flag set -> all outputs 0 and state IDLE next cycle. A subsequent start behaves exactly as in scenario 1.
